rosc_stress_meas_seq: RTL and testbench

Single-clock sequencer directly upstream of the RVT stress ring-oscillator block; it drives every control input of that block (SEL_INV/NAND/NOR, START, AC_DC, AC_STRESS_CLK, EN_POWER_ROSC, EN_ROSC, MEAS_STRESS). A host issues a command (ring select, AC/DC, stress length, measure length) over a valid/ready handshake. The block then runs power-up, stress, switch-over and measurement phases with exact cycle timing. The downstream edge counter on the oscillator OUT uses START as its gate.

---
 rtl/rosc_stress_meas_seq.sv | 220 ++++++++++++++++++++++
 tb/tb_rosc_stress_meas_seq.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rosc_stress_meas_seq.sv
// Control sequencer for the RVT stress ring oscillator: power-up, stress, switch-over,
// gated measurement and post-settle phases, driven by one host command at a time.
module rosc_stress_meas_seq #(
  parameter int unsigned STRESS_W   = 24,
  parameter int unsigned MEAS_W     = 16,
  parameter int unsigned DIV_W      = 8,
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                CMD_VALID,
  output logic                CMD_READY,
  input  logic [1:0]          CMD_SEL,
  input  logic                CMD_AC,
  input  logic [STRESS_W-1:0] CMD_STRESS_LEN,
  input  logic [MEAS_W-1:0]   CMD_MEAS_LEN,
  input  logic [DIV_W-1:0]    CMD_AC_DIV,
  input  logic                ABORT,
  output logic                SEL_INV,
  output logic                SEL_NAND,
  output logic                SEL_NOR,
  output logic                START,
  output logic                AC_DC,
  output logic                AC_STRESS_CLK,
  output logic                EN_POWER_ROSC,
  output logic                EN_ROSC,
  output logic                MEAS_STRESS,
  output logic                BUSY,
  output logic                DONE,
  output logic                ERR
);

  localparam int unsigned LEN_W = (STRESS_W > MEAS_W) ? STRESS_W : MEAS_W;
  localparam int unsigned SET_W = $clog2(SETTLE_CYC + 1);
  localparam int unsigned CNT_W = (LEN_W > SET_W) ? LEN_W : SET_W;
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);

  localparam logic [1:0] SEL_INV_C  = 2'd0;
  localparam logic [1:0] SEL_NAND_C = 2'd1;
  localparam logic [1:0] SEL_NOR_C  = 2'd2;
  localparam logic [1:0] SEL_BAD_C  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PWR_UP,
    S_STRESS,
    S_SWITCH,
    S_MEAS,
    S_POST
  } state_t;

  typedef struct packed {
    logic [1:0]          sel;
    logic                ac;
    logic [STRESS_W-1:0] stress_len;
    logic [MEAS_W-1:0]   meas_len;
    logic [DIV_W-1:0]    ac_div;
  } cmd_t;

  typedef struct packed {
    logic ready;
    logic sel_inv;
    logic sel_nand;
    logic sel_nor;
    logic start;
    logic ac_dc;
    logic ac_clk;
    logic en_power;
    logic en_rosc;
    logic meas_stress;
    logic busy;
    logic done;
    logic err;
  } ctl_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DIV_W-1:0]   dcnt_q, dcnt_d;
  cmd_t               cmd_q, cmd_in, cmd_act;
  ctl_t               out_q, out_d;
  logic               accept, legal, abort_hit, cnt_last, tog;

  assign cmd_in = '{sel: CMD_SEL, ac: CMD_AC, stress_len: CMD_STRESS_LEN,
                    meas_len: CMD_MEAS_LEN, ac_div: CMD_AC_DIV};

  assign accept    = CMD_VALID && out_q.ready && (state_q == S_IDLE);
  assign legal     = (CMD_SEL != SEL_BAD_C) && (CMD_MEAS_LEN != '0);
  assign abort_hit = ABORT && (state_q != S_IDLE);
  assign cnt_last  = (cnt_q == '0);
  // The command register only lands on the accept edge, so the first PWR_UP outputs use the live fields.
  assign cmd_act   = (state_q == S_IDLE) ? cmd_in : cmd_q;

  // State, counters, command and registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dcnt_q      <= '0;
      cmd_q       <= '0;
      out_q       <= '0;
      out_q.ready <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dcnt_q  <= dcnt_d;
      out_q   <= out_d;
      if (accept) begin
        cmd_q <= cmd_in;
      end
    end
  end

  // Next state, phase down-counter and stress-clock divider
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_last ? cnt_q : cnt_q - CNT_W'(1);
    dcnt_d  = dcnt_q;
    tog     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept && legal) begin
          state_d = S_PWR_UP;
          cnt_d   = SETTLE_LD;
        end
      end
      S_PWR_UP: begin
        if (cnt_last) begin
          if (cmd_q.stress_len != '0) begin
            state_d = S_STRESS;
            cnt_d   = CNT_W'(cmd_q.stress_len - STRESS_W'(1));
          end else begin
            state_d = S_SWITCH;
            cnt_d   = SETTLE_LD;
          end
        end
      end
      S_STRESS: begin
        if (cnt_last) begin
          state_d = S_SWITCH;
          cnt_d   = SETTLE_LD;
        end
      end
      S_SWITCH: begin
        if (cnt_last) begin
          state_d = S_MEAS;
          cnt_d   = CNT_W'(cmd_q.meas_len - MEAS_W'(1));
        end
      end
      S_MEAS: begin
        if (cnt_last) begin
          state_d = S_POST;
          cnt_d   = SETTLE_LD;
        end
      end
      S_POST: begin
        if (cnt_last) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (abort_hit) begin
      state_d = S_IDLE;
    end
    if (state_d == S_STRESS) begin
      if (state_q != S_STRESS) begin
        dcnt_d = cmd_q.ac_div;
      end else if (dcnt_q == '0) begin
        dcnt_d = cmd_q.ac_div;
        tog    = 1'b1;
      end else begin
        dcnt_d = dcnt_q - DIV_W'(1);
      end
    end
  end

  // Output decode from the upcoming state, registered above
  always_comb begin
    out_d       = '0;
    out_d.ready = (state_d == S_IDLE) && !accept;
    out_d.busy  = (state_d != S_IDLE);
    out_d.done  = (state_q == S_POST) && (state_d == S_IDLE) && !abort_hit;
    out_d.err   = (accept && !legal) || abort_hit;
    if (state_d != S_IDLE) begin
      out_d.en_power = 1'b1;
      out_d.sel_inv  = (cmd_act.sel == SEL_INV_C);
      out_d.sel_nand = (cmd_act.sel == SEL_NAND_C);
      out_d.sel_nor  = (cmd_act.sel == SEL_NOR_C);
    end
    case (state_d)
      S_PWR_UP: out_d.ac_dc = cmd_act.ac;
      S_STRESS: begin
        out_d.ac_dc  = cmd_act.ac;
        out_d.ac_clk = cmd_act.ac && (state_q == S_STRESS) && (out_q.ac_clk ^ tog);
      end
      S_SWITCH, S_POST: out_d.meas_stress = 1'b1;
      S_MEAS: begin
        out_d.meas_stress = 1'b1;
        out_d.en_rosc     = 1'b1;
        out_d.start       = 1'b1;
      end
      default: ;
    endcase
  end

  assign CMD_READY     = out_q.ready;
  assign SEL_INV       = out_q.sel_inv;
  assign SEL_NAND      = out_q.sel_nand;
  assign SEL_NOR       = out_q.sel_nor;
  assign START         = out_q.start;
  assign AC_DC         = out_q.ac_dc;
  assign AC_STRESS_CLK = out_q.ac_clk;
  assign EN_POWER_ROSC = out_q.en_power;
  assign EN_ROSC       = out_q.en_rosc;
  assign MEAS_STRESS   = out_q.meas_stress;
  assign BUSY          = out_q.busy;
  assign DONE          = out_q.done;
  assign ERR           = out_q.err;

endmodule

// File: tb/tb_rosc_stress_meas_seq.sv
// Bench for rosc_stress_meas_seq: directed command table, hand corner sequences and
// random commands, each cycle compared with a phase-arithmetic model of the sequence.
module tb_rosc_stress_meas_seq;

  localparam int STRESS_W = 24;
  localparam int MEAS_W   = 16;
  localparam int DIV_W    = 8;
  localparam int SETTLE   = 4;

  logic CLK = 1'b0;
  logic RST, CMD_VALID, CMD_READY, CMD_AC, ABORT;
  logic [1:0]          CMD_SEL;
  logic [STRESS_W-1:0] CMD_STRESS_LEN;
  logic [MEAS_W-1:0]   CMD_MEAS_LEN;
  logic [DIV_W-1:0]    CMD_AC_DIV;
  logic SEL_INV, SEL_NAND, SEL_NOR, START, AC_DC, AC_STRESS_CLK;
  logic EN_POWER_ROSC, EN_ROSC, MEAS_STRESS, BUSY, DONE, ERR;

  always #5 CLK = ~CLK;

  rosc_stress_meas_seq #(
    .STRESS_W(STRESS_W), .MEAS_W(MEAS_W), .DIV_W(DIV_W), .SETTLE_CYC(SETTLE)
  ) dut (
    .CLK(CLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_SEL(CMD_SEL), .CMD_AC(CMD_AC), .CMD_STRESS_LEN(CMD_STRESS_LEN),
    .CMD_MEAS_LEN(CMD_MEAS_LEN), .CMD_AC_DIV(CMD_AC_DIV), .ABORT(ABORT),
    .SEL_INV(SEL_INV), .SEL_NAND(SEL_NAND), .SEL_NOR(SEL_NOR), .START(START),
    .AC_DC(AC_DC), .AC_STRESS_CLK(AC_STRESS_CLK), .EN_POWER_ROSC(EN_POWER_ROSC),
    .EN_ROSC(EN_ROSC), .MEAS_STRESS(MEAS_STRESS), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  typedef struct packed {
    logic ready, sel_inv, sel_nand, sel_nor, start, ac_dc, ac_clk;
    logic en_pwr, en_rosc, meas_stress, busy, done, err;
  } obs_t;

  typedef struct {
    int sel; int ac; int stress; int meas; int div;
    int abort_at; int abort_acc; int trace;
    int exp_done; int exp_start; int exp_achi; int exp_err;
  } vec_t;

  int total = 0;
  int bad   = 0;

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic check_obs(input string name, input int k, input obs_t act, input obs_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle %0d: got %b want %b", name, k, act, exp);
    end
  endtask

  function automatic obs_t sample();
    obs_t o;
    o = '{CMD_READY, SEL_INV, SEL_NAND, SEL_NOR, START, AC_DC, AC_STRESS_CLK,
          EN_POWER_ROSC, EN_ROSC, MEAS_STRESS, BUSY, DONE, ERR};
    return o;
  endfunction

  function automatic obs_t idle_obs();
    obs_t o;
    o = '0;
    o.ready = 1'b1;
    return o;
  endfunction

  function automatic int seq_len(input vec_t v);
    return 3 * SETTLE + v.stress + v.meas;
  endfunction

  // Expected outputs k cycles after the accept edge, from phase boundaries alone
  function automatic obs_t exp_at(input vec_t v, input int k);
    obs_t e;
    int j;
    e = '0;
    if (k >= seq_len(v)) begin
      e.ready = 1'b1;
      e.done  = (k == seq_len(v));
      return e;
    end
    e.busy     = 1'b1;
    e.en_pwr   = 1'b1;
    e.sel_inv  = (v.sel == 0);
    e.sel_nand = (v.sel == 1);
    e.sel_nor  = (v.sel == 2);
    if (k < SETTLE) begin
      e.ac_dc = v.ac[0];
    end else if (k < SETTLE + v.stress) begin
      j = k - SETTLE;
      e.ac_dc  = v.ac[0];
      e.ac_clk = (v.ac != 0) && (((j / (v.div + 1)) % 2) == 1);
    end else if (k < 2 * SETTLE + v.stress) begin
      e.meas_stress = 1'b1;
    end else if (k < 2 * SETTLE + v.stress + v.meas) begin
      e.meas_stress = 1'b1;
      e.en_rosc     = 1'b1;
      e.start       = 1'b1;
    end else begin
      e.meas_stress = 1'b1;
    end
    return e;
  endfunction

  task automatic drive_cmd(input vec_t v);
    CMD_SEL        = 2'(v.sel);
    CMD_AC         = v.ac[0];
    CMD_STRESS_LEN = STRESS_W'(v.stress);
    CMD_MEAS_LEN   = MEAS_W'(v.meas);
    CMD_AC_DIV     = DIV_W'(v.div);
    CMD_VALID      = 1'b1;
  endtask

  // Issue one command starting at a negedge, follow it to completion, return observed totals
  task automatic run_cmd(input vec_t v, output int done_lat, output int start_n,
                         output int achi_n, output int err_n);
    obs_t o, e;
    int   t;
    bit   stop;
    done_lat = -1; start_n = 0; achi_n = 0; err_n = 0;
    check_obs("pre_accept", -1, sample(), idle_obs());
    drive_cmd(v);
    ABORT = v.abort_acc[0];
    @(negedge CLK);
    CMD_VALID = 1'b0;
    ABORT     = 1'b0;
    if (v.sel == 3 || v.meas == 0) begin
      o = sample();
      e = '0;
      e.err = 1'b1;
      err_n += int'(o.err);
      check_obs("illegal_err", 0, o, e);
      @(negedge CLK);
      check_obs("illegal_after", 1, sample(), idle_obs());
      return;
    end
    t = seq_len(v);
    stop = 1'b0;
    for (int k = 0; k <= t && !stop; k++) begin
      o = sample();
      start_n += int'(o.start);
      achi_n  += int'(o.ac_clk);
      err_n   += int'(o.err);
      if (o.done) done_lat = k;
      if (v.trace != 0) check_obs("trace", k, o, exp_at(v, k));
      if (o.start && o.ac_clk) check_int("start_and_acclk", 1, 0);
      if (k == v.abort_at) begin
        ABORT = 1'b1;
        @(negedge CLK);
        ABORT = 1'b0;
        o = sample();
        err_n += int'(o.err);
        e = idle_obs();
        e.err = 1'b1;
        check_obs("abort", k + 1, o, e);
        for (int m = 0; m < 3; m++) begin
          @(negedge CLK);
          o = sample();
          if (o.done) done_lat = k + 2 + m;
          check_obs("post_abort", k + 2 + m, o, idle_obs());
        end
        stop = 1'b1;
      end else begin
        @(negedge CLK);
      end
    end
    if (!stop) check_obs("post_done", t + 1, sample(), idle_obs());
  endtask

  vec_t tbl[7];
  int   dl, sn, an, en;

  initial begin
    // sel ac stress meas div abort_at abort_acc trace | done start achi err
    tbl[0] = '{1, 0, 10, 20, 0, -1, 0, 1,  42, 20, 0, 0};
    tbl[1] = '{0, 1, 12,  5, 2, -1, 0, 1,  29,  5, 6, 0};
    tbl[2] = '{2, 0,  0,  1, 0, -1, 1, 1,  13,  1, 0, 0};
    tbl[3] = '{3, 0,  5,  5, 0, -1, 0, 1,  -1,  0, 0, 1};
    tbl[4] = '{0, 0,  5,  0, 0, -1, 0, 1,  -1,  0, 0, 1};
    tbl[5] = '{2, 1,  7,  3, 0,  8, 0, 1,  -1,  0, 2, 1};
    tbl[6] = '{1, 1,  5,  2, 1, -1, 0, 1,  19,  2, 2, 0};

    RST = 1'b1; CMD_VALID = 1'b0; ABORT = 1'b0; CMD_SEL = '0; CMD_AC = 1'b0;
    CMD_STRESS_LEN = '0; CMD_MEAS_LEN = '0; CMD_AC_DIV = '0;
    repeat (3) @(negedge CLK);
    check_obs("in_reset", 0, sample(), idle_obs());
    RST = 1'b0;
    @(negedge CLK);
    check_obs("after_reset", 0, sample(), idle_obs());

    // ABORT while idle has no effect
    ABORT = 1'b1;
    repeat (2) @(negedge CLK);
    ABORT = 1'b0;
    check_obs("idle_abort", 0, sample(), idle_obs());

    foreach (tbl[i]) begin
      run_cmd(tbl[i], dl, sn, an, en);
      check_int($sformatf("vec%0d_done_lat", i), dl, tbl[i].exp_done);
      check_int($sformatf("vec%0d_start_cnt", i), sn, tbl[i].exp_start);
      check_int($sformatf("vec%0d_acclk_hi", i), an, tbl[i].exp_achi);
      check_int($sformatf("vec%0d_err_cnt", i), en, tbl[i].exp_err);
    end

    // Reset in the middle of the measurement window
    begin
      vec_t r;
      r = '{0, 0, 2, 10, 0, -1, 0, 1, 0, 0, 0, 0};
      drive_cmd(r);
      @(negedge CLK);
      CMD_VALID = 1'b0;
      repeat (2 * SETTLE + 2 + 3) @(negedge CLK);
      check_int("meas_start_hi", int'(START), 1);
      RST = 1'b1;
      @(negedge CLK);
      check_obs("reset_in_meas", 0, sample(), idle_obs());
      RST = 1'b0;
      @(negedge CLK);
      check_obs("after_meas_reset", 0, sample(), idle_obs());
    end

    // Random commands against the phase model
    for (int n = 0; n < 30; n++) begin
      vec_t v;
      int exp_dl;
      v.sel      = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
      v.ac       = int'($urandom_range(0, 1));
      v.stress   = int'($urandom_range(0, 25));
      v.meas     = int'($urandom_range(0, 15));
      v.div      = int'($urandom_range(0, 4));
      v.abort_acc = int'($urandom_range(0, 5) == 0);
      v.abort_at = ($urandom_range(0, 3) == 0) ?
                   int'($urandom_range(0, 3 * SETTLE + 24)) : -1;
      if (v.abort_at >= seq_len(v)) v.abort_at = -1;
      v.trace = 1;
      run_cmd(v, dl, sn, an, en);
      exp_dl = (v.sel == 3 || v.meas == 0 || v.abort_at >= 0) ? -1 : seq_len(v);
      check_int($sformatf("rnd%0d_done_lat", n), dl, exp_dl);
      check_int($sformatf("rnd%0d_err_cnt", n), en, (exp_dl < 0) ? 1 : 0);
    end

    // Full-scale measurement window must not wrap
    begin
      vec_t w;
      w = '{1, 0, 0, 65535, 0, -1, 0, 0, 0, 0, 0, 0};
      run_cmd(w, dl, sn, an, en);
      check_int("maxmeas_done_lat", dl, 3 * SETTLE + 65535);
      check_int("maxmeas_start_cnt", sn, 65535);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
